// File: rtl/enable_register_if.sv
// Bus bundle for enable_register: write controls, data and status.
// Parity signals exist only when ENABLE_REGISTER_PARITY_EN is defined.
interface enable_register_if #(
  parameter int WIDTH = 32
);
  localparam int NBYTES = WIDTH / 8;

  logic              en;
  logic [NBYTES-1:0] be;
  logic              clr;
  logic [WIDTH-1:0]  D;
  logic [WIDTH-1:0]  Q;
  logic              loaded;
`ifdef ENABLE_REGISTER_PARITY_EN
  logic              par;
  logic              par_inject;
  logic              par_err;
`endif

  modport master (
    output en, be, clr, D,
`ifdef ENABLE_REGISTER_PARITY_EN
    output par_inject,
    input  par, par_err,
`endif
    input  Q, loaded
  );

  modport slave (
    input  en, be, clr, D,
`ifdef ENABLE_REGISTER_PARITY_EN
    input  par_inject,
    output par, par_err,
`endif
    output Q, loaded
  );
endinterface

// File: rtl/enable_register.sv
// Width-parameterised register with load enable, byte strobes, sync clear and sync reset.
// Optional stored-parity output and error flag under ENABLE_REGISTER_PARITY_EN.
module enable_register #(
  parameter int             WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input logic              clk,
  input logic              rst,
  enable_register_if.slave bus
);
  localparam int NBYTES = WIDTH / 8;

  logic [WIDTH-1:0] data_d, data_q;
  logic             loaded_d, loaded_q;

  // NOTE: next-state logic starts from "hold" defaults so every path assigns
  // every signal; without them this block would infer latches.
  always_comb begin
    data_d   = data_q;
    loaded_d = 1'b0;
    if (bus.clr) begin
      data_d = RESET_VALUE;
    end else if (bus.en) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (bus.be[i]) data_d[8*i +: 8] = bus.D[8*i +: 8];
      end
      loaded_d = |bus.be;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update
  // together from values sampled before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q   <= RESET_VALUE;
      loaded_q <= 1'b0;
    end else begin
      data_q   <= data_d;
      loaded_q <= loaded_d;
    end
  end

  assign bus.Q      = data_q;
  assign bus.loaded = loaded_q;

`ifdef ENABLE_REGISTER_PARITY_EN
  localparam logic RESET_PAR = ^RESET_VALUE;

  logic par_d, par_q;

  // Parity tracks the new word on a real write; par_inject flips it so the
  // checker downstream can be exercised.
  always_comb begin
    par_d = par_q;
    if (bus.clr) begin
      par_d = RESET_PAR;
    end else if (bus.en && (|bus.be)) begin
      par_d = (^data_d) ^ bus.par_inject;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) par_q <= RESET_PAR;
    else     par_q <= par_d;
  end

  assign bus.par     = par_q;
  assign bus.par_err = (^data_q) ^ par_q;
`endif
endmodule

// File: tb/tb_enable_register.sv
// Directed self-checking bench for enable_register (WIDTH=32, RESET_VALUE=0).
// Parity steps run only when ENABLE_REGISTER_PARITY_EN is defined.
module tb_enable_register;
  logic clk;
  logic rst;
  int   compared;
  int   mismatched;

  enable_register_if #(.WIDTH(32)) bus ();

  enable_register #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Inputs are driven on the falling edge; one rising edge follows, then
  // outputs are sampled on the next falling edge.
  task automatic drive(input logic r, input logic c, input logic e,
                       input logic [3:0] b, input logic [31:0] d);
    rst     = r;
    bus.clr = c;
    bus.en  = e;
    bus.be  = b;
    bus.D   = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
`ifdef ENABLE_REGISTER_PARITY_EN
    bus.par_inject = 1'b0;
`endif

    // Reset
    drive(1'b1, 1'b0, 1'b0, 4'h0, 32'd0);
    check_word("reset_q", bus.Q, 32'd0);
    check_bit("reset_loaded", bus.loaded, 1'b0);

    // Full-word load of 26 (driven at 20 ns, captured at 30 ns)
    drive(1'b0, 1'b0, 1'b1, 4'hF, 32'd26);
    check_word("load26_q", bus.Q, 32'd26);
    check_bit("load26_loaded", bus.loaded, 1'b1);

    // Hold for 80 ns with D=0
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 1'b0, 4'hF, 32'd0);
      check_word("hold26_q", bus.Q, 32'd26);
      check_bit("hold26_loaded", bus.loaded, 1'b0);
    end

    drive(1'b0, 1'b0, 1'b1, 4'hF, 32'd28);
    check_word("load28_q", bus.Q, 32'd28);
    check_bit("load28_loaded", bus.loaded, 1'b1);

    drive(1'b0, 1'b0, 1'b0, 4'hF, 32'd0);
    check_word("hold28_q", bus.Q, 32'd28);
    check_bit("hold28_loaded", bus.loaded, 1'b0);

    // Same-value reload still counts as a write
    drive(1'b0, 1'b0, 1'b1, 4'hF, 32'd28);
    check_word("reload28_q", bus.Q, 32'd28);
    check_bit("reload28_loaded", bus.loaded, 1'b1);

    // No combinational path from inputs to outputs
    bus.en = 1'b1;
    bus.be = 4'hF;
    bus.D  = 32'hDEAD_BEEF;
    #1;
    check_word("nocomb_q", bus.Q, 32'd28);
    check_bit("nocomb_loaded", bus.loaded, 1'b1);

    // Byte lanes
    drive(1'b0, 1'b0, 1'b1, 4'hF, 32'h1122_3344);
    check_word("lanes_base_q", bus.Q, 32'h1122_3344);
    drive(1'b0, 1'b0, 1'b1, 4'b0101, 32'hAABB_CCDD);
    check_word("lanes_0101_q", bus.Q, 32'h11BB_33DD);
    check_bit("lanes_0101_loaded", bus.loaded, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 4'b1010, 32'h5566_7788);
    check_word("lanes_1010_q", bus.Q, 32'h55BB_77DD);
    drive(1'b0, 1'b0, 1'b1, 4'b0000, 32'hFFFF_FFFF);
    check_word("lanes_none_q", bus.Q, 32'h55BB_77DD);
    check_bit("lanes_none_loaded", bus.loaded, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 4'hF, 32'hFFFF_FFFF);
    check_word("en_low_ignored_q", bus.Q, 32'h55BB_77DD);
    check_bit("en_low_ignored_loaded", bus.loaded, 1'b0);

    // Priority: rst > clr > en
    drive(1'b0, 1'b0, 1'b1, 4'hF, 32'd28);
    check_word("prio_pre_q", bus.Q, 32'd28);
    drive(1'b1, 1'b1, 1'b1, 4'hF, 32'd5);
    check_word("prio_rst_q", bus.Q, 32'd0);
    check_bit("prio_rst_loaded", bus.loaded, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 4'hF, 32'd5);
    check_word("prio_clr_q", bus.Q, 32'd0);
    check_bit("prio_clr_loaded", bus.loaded, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 4'hF, 32'd5);
    check_word("prio_en_q", bus.Q, 32'd5);
    check_bit("prio_en_loaded", bus.loaded, 1'b1);

    // Clear alone, then reset followed immediately by a write
    drive(1'b0, 1'b1, 1'b0, 4'h0, 32'd0);
    check_word("clr_only_q", bus.Q, 32'd0);
    drive(1'b0, 1'b0, 1'b1, 4'hF, 32'd77);
    drive(1'b1, 1'b0, 1'b0, 4'h0, 32'd0);
    check_word("rst_mid_q", bus.Q, 32'd0);
    drive(1'b0, 1'b0, 1'b1, 4'hF, 32'd9);
    check_word("post_rst_write_q", bus.Q, 32'd9);
    check_bit("post_rst_write_loaded", bus.loaded, 1'b1);

`ifdef ENABLE_REGISTER_PARITY_EN
    drive(1'b0, 1'b0, 1'b1, 4'hF, 32'h7);
    check_bit("par_d7", bus.par, 1'b1);
    check_bit("par_err_d7", bus.par_err, 1'b0);
    bus.par_inject = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 4'hF, 32'h7);
    check_bit("par_inj", bus.par, 1'b0);
    check_bit("par_err_inj", bus.par_err, 1'b1);
    bus.par_inject = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 4'hF, 32'h0);
    check_bit("par_err_hold", bus.par_err, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 4'hF, 32'h3);
    check_bit("par_d3", bus.par, 1'b0);
    check_bit("par_err_clean", bus.par_err, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 4'h0, 32'h0);
    check_bit("par_clr", bus.par, 1'b0);
    check_bit("par_err_clr", bus.par_err, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/enable_register.md
Name: enable_register

Overview:
- Parameterizable-width storage register with synchronous load enable, per-byte write strobes, synchronous clear and synchronous reset.
- General-purpose datapath state element: pipeline or architectural registers and configuration holders in the lab processor datapath.
- Default configuration is a 32-bit word register loaded when `en` is high and holding otherwise.

Parameters:
- WIDTH, 32, data width in bits; must be a multiple of 8 and at least 8.
- RESET_VALUE, {WIDTH{1'b0}}, value loaded into Q on reset and on clear.
- NBYTES, WIDTH/8, derived byte-lane count; not to be overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- en  input  1  load enable; write occurs on the clk rising edge when high.
- be  input  NBYTES  byte write strobes; bit i gates D[8i+7:8i]; tie all-ones for full-word writes.
- clr  input  1  synchronous clear to RESET_VALUE, active-high.
- D  input  WIDTH  write data.
- Q  output  WIDTH  stored value, driven directly from flops.
- loaded  output  1  high for one cycle after any edge where Q was written by D.

Behaviour:
- All state updates occur on the rising edge of clk; there is no asynchronous path.
- Priority at each edge, highest first:
  - rst: Q <= RESET_VALUE, loaded <= 0.
  - clr: Q <= RESET_VALUE, loaded <= 0.
  - en: for each lane i with be[i]=1, Q lane i <= D lane i; lanes with be[i]=0 hold. loaded <= 1 if any be bit is set, else 0.
  - otherwise: Q holds, loaded <= 0.
- Reset values: Q = RESET_VALUE, loaded = 0.
- Latency:
  - Q reflects D one edge after en/D are sampled.
  - No combinational path from D, en, be or clr to Q or loaded.
- en=1 with be=0: no lane changes and loaded=0; this is a legal no-op.
- Reloading the same value is a write: loaded=1 even though Q is unchanged.
- D and be are ignored while en=0.
- rst asserted mid-operation overrides any concurrent en/clr on that edge.
- Deasserting rst allows a write on the very next edge.
- Before the first reset, Q is X in simulation; no initial value is required.
- Inputs may change anywhere within the cycle; only values at the rising edge matter.

Optional Feature:
- Macro: ENABLE_REGISTER_PARITY_EN.
- When defined:
  - Adds an output port `par` (1 bit) holding the even parity (XOR reduction) of the stored Q, updated on the same edge as Q.
  - Reset and clear set `par` to the parity of RESET_VALUE.
  - Adds an input `par_inject` (1 bit); when high on a write edge, the stored parity bit is inverted, for error-detection testing.
  - Adds an output `par_err` (combinational) = XOR reduction of Q XOR `par`.
- When undefined: `par`, `par_inject` and `par_err` do not exist, and no parity logic is synthesized.

Test Plan:
- Reset with rst=1 for one edge, WIDTH=32 -> Q=0, loaded=0.
- Full-word load: 20 ns clock, en=1, be=4'hF, D=26 applied at 20 ns -> Q=26 after the 30 ns edge, loaded=1 for one cycle.
- Hold:
  - Then en=0, D=0 for 80 ns -> Q stays 26 and loaded=0.
  - Then en=1, D=28 -> Q=28 after the next edge.
  - Then en=0, D=0 -> Q stays 28.
- Byte lanes: Q=32'h11223344, en=1, be=4'b0101, D=32'hAABBCCDD -> Q=32'h11BB33DD, loaded=1.
  - Same with be=0 -> Q unchanged, loaded=0.
- Priority:
  - Q=28; rst=1, clr=1, en=1, D=5 on the same edge -> Q=0.
  - Next edge with clr=1, en=1 -> Q=0.
  - Next edge with en=1 only -> Q=5.
- Parity (with ENABLE_REGISTER_PARITY_EN):
  - Write D=32'h7 -> par=1, par_err=0.
  - Write with par_inject=1 -> par_err=1 until the next clean write.
